// File: rtl/ripple_count_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ripple_count_pkg
// Purpose : Shared types and constants for ripple_count_monitor: FSM state
//           enum, parameter defaults, onehot reset value and decode helper.
// Revision: 1.0 - initial release
// ============================================================================
package ripple_count_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } rcm_state_t;

  localparam int         C_DEF_STABLE_CYCLES = 3;
  localparam int         C_DEF_WRAP_W        = 8;
  localparam logic [3:0] C_ONEHOT_RST        = 4'b0001;

  // One-hot decode of a 2-bit count value
  function automatic logic [3:0] f_onehot(input logic [1:0] i_v);
    return 4'b0001 << i_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rcm_sync2.sv
`default_nettype none
// ============================================================================
// Module  : rcm_sync2
// Purpose : Single-bit two-flop synchronizer, asynchronous active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
module rcm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to resolve metastability on the async input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module  : ripple_count_monitor
// Purpose : Synchronizes a 2-bit ripple counter, filters ripple glitches by
//           requiring a value to hold STABLE_CYCLES, and reports each accepted
//           change as a valid/ready event with wrap/skip classification.
// Config  : RCM_WRAP_COUNT_EN - when defined, builds the wrap_count register;
//           otherwise wrap_count is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module ripple_count_monitor
  import ripple_count_pkg::*;
#(
  parameter int STABLE_CYCLES = C_DEF_STABLE_CYCLES,
  parameter int WRAP_W        = C_DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              count0,
  input  logic              count1,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_value,
  output logic              evt_wrap,
  output logic              evt_skip,
  output logic [3:0]        onehot,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [3:0] C_STABLE = 4'(STABLE_CYCLES);

  logic       w_s0;
  logic       w_s1;
  logic [1:0] w_s;

  rcm_sync2 u_sync0 (.clk(clk), .rst_n(rst_n), .i_d(count0), .o_q(w_s0));
  rcm_sync2 u_sync1 (.clk(clk), .rst_n(rst_n), .i_d(count1), .o_q(w_s1));

  assign w_s = {w_s1, w_s0};

  rcm_state_t r_state;
  rcm_state_t w_state_nxt;
  logic [1:0] r_stab;
  logic [1:0] r_cand;
  logic [1:0] w_cand_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic       w_commit;
  logic       w_wrap;
  logic       w_skip;
  logic [1:0] w_stab_inc;
  logic       w_drop;

  logic       r_evt_valid;
  logic [1:0] r_evt_value;
  logic       r_evt_wrap;
  logic       r_evt_skip;
  logic [3:0] r_onehot;
  logic       r_overrun;

  // FSM state, candidate and settle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cand  <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: track a candidate until it has held long enough to commit
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s != r_stab) begin
          w_cand_nxt  = w_s;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_s == r_stab) begin
          // glitch reverted to the accepted value
          w_state_nxt = ST_IDLE;
        end else if (w_s != r_cand) begin
          // intermediate ripple state: restart on the new value
          w_cand_nxt = w_s;
          w_cnt_nxt  = 4'd1;
        end else if (r_cnt == C_STABLE) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_commit   = (r_state == ST_COMMIT);
  assign w_stab_inc = r_stab + 2'd1;
  assign w_wrap     = (r_stab == 2'd3) && (r_cand == 2'd0);
  assign w_skip     = (r_cand != w_stab_inc);
  assign w_drop     = w_commit && r_evt_valid && !evt_ready;

  // Accepted value and its one-hot decode, both updated on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab   <= 2'd0;
      r_onehot <= C_ONEHOT_RST;
    end else if (w_commit) begin
      r_stab   <= r_cand;
      r_onehot <= f_onehot(r_cand);
    end
  end

  // Single-entry event slot; a new event overwrites an unconsumed one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_value <= 2'd0;
      r_evt_wrap  <= 1'b0;
      r_evt_skip  <= 1'b0;
    end else if (w_commit) begin
      r_evt_valid <= 1'b1;
      r_evt_value <= r_cand;
      r_evt_wrap  <= w_wrap;
      r_evt_skip  <= w_skip;
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef RCM_WRAP_COUNT_EN
  logic [WRAP_W-1:0] r_wrap_count;

  // Count wrap events regardless of whether they are consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap_count <= '0;
    end else if (w_commit && w_wrap) begin
      r_wrap_count <= r_wrap_count + 1'b1;
    end
  end

  assign wrap_count = r_wrap_count;
`else
  assign wrap_count = '0;
`endif

  assign evt_valid = r_evt_valid;
  assign evt_value = r_evt_value;
  assign evt_wrap  = r_evt_wrap;
  assign evt_skip  = r_evt_skip;
  assign onehot    = r_onehot;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_ripple_count_monitor
// Purpose : Scoreboard bench for ripple_count_monitor. A run-length reference
//           model predicts accepted values and events; a monitor pops and
//           compares on every transfer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ripple_count_monitor;

  localparam int S  = 3;
  localparam int WW = 8;
`ifdef RCM_WRAP_COUNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          count0 = 1'b0;
  logic          count1 = 1'b0;
  logic          evt_ready = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_value;
  logic          evt_wrap;
  logic          evt_skip;
  logic [3:0]    onehot;
  logic          overrun;
  logic [WW-1:0] wrap_count;

  int checks = 0;
  int errors = 0;

  ripple_count_monitor #(.STABLE_CYCLES(S), .WRAP_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .count0(count0), .count1(count1),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_value(evt_value),
    .evt_wrap(evt_wrap), .evt_skip(evt_skip), .onehot(onehot),
    .overrun(overrun), .clr_overrun(clr_overrun), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic       w;
    logic       k;
  } ev_t;

  ev_t q[$];

  // reference model state
  logic [1:0]    m_p1, m_p2, m_stab, m_last, m_pv, m_s;
  int            m_run;
  bit            m_cpend, m_valid, m_ovr, m_ev, m_ovr_set;
  logic [WW-1:0] m_wc;
  ev_t           m_e;

  // monitor observations
  int         n_xfer = 0;
  logic [1:0] last_val = 2'd0;
  logic       last_wrap = 1'b0;
  logic       last_skip = 1'b0;
  ev_t        mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a value is accepted once the synchronized input has shown it,
  // differing from the accepted value, for S+1 consecutive sampled edges; the
  // event appears one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_stab = 0; m_last = 0; m_pv = 0;
      m_run = 0; m_cpend = 0; m_valid = 0; m_ovr = 0; m_wc = 0;
      q.delete();
    end else begin
      m_s = m_p2;
      m_ev = 0;
      m_ovr_set = 0;
      if (m_cpend) begin
        m_e.v = m_pv;
        m_e.w = (m_stab == 2'd3) && (m_pv == 2'd0);
        m_e.k = (int'(m_pv) != ((int'(m_stab) + 1) % 4));
        m_stab = m_pv;
        m_cpend = 0;
        m_run = 0;
        m_ev = 1;
      end else begin
        if (m_s == m_stab) m_run = 0;
        else if (m_run > 0 && m_s == m_last) m_run++;
        else begin m_run = 1; m_last = m_s; end
        if (m_run == S + 1) begin m_cpend = 1; m_pv = m_last; end
      end
      if (m_ev) begin
        if (m_valid && !evt_ready) begin
          m_ovr_set = 1;
          if (q.size() > 0) q[q.size()-1] = m_e;
          else q.push_back(m_e);
        end else begin
          q.push_back(m_e);
        end
        m_valid = 1;
        if (m_e.w && WC_EN) m_wc = m_wc + 1'b1;
      end else if (m_valid && evt_ready) begin
        m_valid = 0;
      end
      if (m_ovr_set) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      m_p2 = m_p1;
      m_p1 = {count1, count0};
    end
  end

  // Monitor: status every cycle, payload on each transfer
  always @(negedge clk) begin
    chk("evt_valid", evt_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("onehot", onehot, 1 << m_stab);
    chk("wrap_count", wrap_count, m_wc);
    if (rst_n && evt_valid && evt_ready) begin
      chk("evt_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("evt_value", evt_value, mon_e.v);
        chk("evt_wrap", evt_wrap, mon_e.w);
        chk("evt_skip", evt_skip, mon_e.k);
      end
      n_xfer++;
      last_val = evt_value;
      last_wrap = evt_wrap;
      last_skip = evt_skip;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setp(input logic [1:0] v);
    {count1, count0} = v;
  endtask

  int lat;
  int x0;

  initial begin
    // reset state
    rst_n = 1'b0;
    cyc(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_onehot", onehot, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_wrap_count", wrap_count, 0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cyc(2);

    // clean step 0->1 with latency measurement
    setp(2'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (evt_valid) begin lat = i; break; end
    end
    chk("clean_latency", lat, S + 4);
    chk("clean_value", evt_value, 1);
    chk("clean_skip", evt_skip, 0);
    chk("clean_wrap", evt_wrap, 0);
    @(posedge clk); #1;
    chk("clean_pulse", evt_valid, 0);
    chk("clean_onehot", onehot, 4'b0010);
    cyc(5);

    // ripple glitch 1 -> 0 (one clk) -> 2
    x0 = n_xfer;
    setp(2'd0); cyc(1);
    setp(2'd2); cyc(12);
    chk("glitch_events", n_xfer - x0, 1);
    chk("glitch_value", last_val, 2);
    chk("glitch_skip", last_skip, 0);

    // skip 0 -> 2
    setp(2'd0); cyc(12);
    setp(2'd2); cyc(12);
    chk("skip_value", last_val, 2);
    chk("skip_skip", last_skip, 1);
    chk("skip_wrap", last_wrap, 0);

    // wrap 3 -> 0
    setp(2'd3); cyc(12);
    setp(2'd0); cyc(12);
    chk("wrap_flag", last_wrap, 1);
    chk("wrap_inc", wrap_count, WC_EN ? 1 : 0);

    // reset in the middle of SETTLE
    setp(2'd1); cyc(4);
    rst_n = 1'b0;
    setp(2'd0);
    cyc(2);
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_onehot", onehot, 1);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_wrap_count", wrap_count, 0);
    rst_n = 1'b1;
    x0 = n_xfer;
    cyc(15);
    chk("midrst_no_event", n_xfer - x0, 0);

    // backpressure and overrun
    evt_ready = 1'b0;
    setp(2'd1); cyc(12);
    setp(2'd2); cyc(12);
    chk("bp_overrun", overrun, 1);
    chk("bp_value", evt_value, 2);
    chk("bp_valid", evt_valid, 1);
    clr_overrun = 1'b1; cyc(1);
    clr_overrun = 1'b0;
    chk("bp_clr", overrun, 0);
    x0 = n_xfer;
    evt_ready = 1'b1; cyc(3);
    chk("bp_one_xfer", n_xfer - x0, 1);
    chk("bp_xfer_value", last_val, 2);

    // wrap counter rollover
    setp(2'd0); cyc(12);
    for (int i = 0; i < 255; i++) begin
      setp(2'd3); cyc(S + 6);
      setp(2'd0); cyc(S + 6);
    end
    chk("wrap_255", wrap_count, WC_EN ? 255 : 0);
    setp(2'd3); cyc(S + 6);
    setp(2'd0); cyc(S + 6);
    chk("wrap_rollover", wrap_count, 0);

    // randomized pins, backpressure and clears
    repeat (600) begin
      setp(2'($urandom_range(0, 3)));
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 9) == 0);
      cyc($urandom_range(1, 8));
    end

    // drain
    evt_ready = 1'b1;
    clr_overrun = 1'b0;
    cyc(20);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
